// File: rtl/truth_table_sweeper_if.sv
// Sweep bus between the truth-table sweeper (master) and the DUT/controller side (slave).
// It carries the start strobe, the driven minterm, the DUT output and the captured results.
interface truth_table_sweeper_if #(
    parameter int N_IN = 2
);
    localparam int M = 2 ** N_IN;

    logic            start;
    logic [N_IN-1:0] x;
    logic            s_in;
    logic            busy;
    logic            done;
    logic            pass;
    logic [N_IN:0]   err_count;
    logic [N_IN-1:0] first_err;
    logic            first_err_valid;
    logic [M-1:0]    cap_table;

    modport master (
        input  start, s_in,
        output x, busy, done, pass, err_count, first_err, first_err_valid, cap_table
    );

    modport slave (
        output start, s_in,
        input  x, busy, done, pass, err_count, first_err, first_err_valid, cap_table
    );
endinterface

// File: rtl/truth_table_sweeper.sv
// Walks every input minterm of a combinational DUT, samples its output after a settle window
// and checks the captured truth table against EXPECT.
module truth_table_sweeper #(
    parameter int               N_IN   = 2,
    parameter int               SETTLE = 1,
    parameter logic [2**N_IN-1:0] EXPECT = 4'b0010
) (
    input  logic                clock,
    input  logic                reset,
    truth_table_sweeper_if.master bus
);
    localparam int M = 2 ** N_IN;

    // WAIT covers SETTLE cycles and SAMPLE the last one, so each minterm lasts SETTLE+1 cycles.
    localparam logic [3:0] CNT_LD = (SETTLE == 0) ? 4'd0 : 4'(SETTLE - 1);

    typedef enum logic [1:0] {IDLE, WAIT, SAMPLE, DONE} state_t;

    state_t        state;
    logic [3:0]    cnt;
    logic          mis;
    logic [N_IN:0] err_nxt;

    assign mis     = (bus.s_in != EXPECT[bus.x]);
    assign err_nxt = bus.err_count + (N_IN+1)'(mis);

    always_ff @(posedge clock) begin
        if (reset) begin
            state               <= IDLE;
            cnt                 <= '0;
            bus.x               <= '0;
            bus.busy            <= 1'b0;
            bus.done            <= 1'b0;
            bus.pass            <= 1'b0;
            bus.err_count       <= '0;
            bus.first_err       <= '0;
            bus.first_err_valid <= 1'b0;
            bus.cap_table       <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        bus.x               <= '0;
                        bus.busy            <= 1'b1;
                        bus.done            <= 1'b0;
                        bus.pass            <= 1'b0;
                        bus.err_count       <= '0;
                        bus.first_err       <= '0;
                        bus.first_err_valid <= 1'b0;
                        bus.cap_table       <= '0;
                        cnt                 <= CNT_LD;
                        state               <= (SETTLE == 0) ? SAMPLE : WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) state <= SAMPLE;
                    else             cnt   <= cnt - 4'd1;
                end
                SAMPLE: begin
                    bus.cap_table[bus.x] <= bus.s_in;
                    if (mis) begin
                        bus.err_count <= err_nxt;
                        if (!bus.first_err_valid) begin
                            bus.first_err       <= bus.x;
                            bus.first_err_valid <= 1'b1;
                        end
                    end
                    if (bus.x == N_IN'(M - 1)) begin
                        state    <= DONE;
                        bus.busy <= 1'b0;
                        bus.done <= 1'b1;
                        bus.pass <= (err_nxt == '0);
                    end else begin
                        bus.x <= bus.x + 1'b1;
                        cnt   <= CNT_LD;
                        state <= (SETTLE == 0) ? SAMPLE : WAIT;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
